// File: rtl/imm_ext_pkg.sv
// Shared definitions for the immediate extender: mode encodings and buffer depth.
package imm_ext_pkg;

  typedef enum logic [1:0] {
    IMM_SEXT      = 2'b00,
    IMM_ZEXT      = 2'b01,
    IMM_SEXT_SHL1 = 2'b10,
    IMM_UPPER     = 2'b11
  } imm_mode_e;

  localparam int unsigned FIFO_DEPTH = 2;

endpackage : imm_ext_pkg

// File: rtl/imm_ext_core.sv
// Combinational immediate extender: sign/zero extension, branch-offset
// (sign-extend, shift left 1) and upper placement of an IN_W-bit field.
import imm_ext_pkg::*;

module imm_ext_core #(
  parameter int unsigned IN_W  = 9,
  parameter int unsigned OUT_W = 16
) (
  input  logic [IN_W-1:0]  in_imm,
  input  logic [1:0]       in_mode,
  output logic [OUT_W-1:0] ext_data
);

  logic [OUT_W-1:0] sext;
  logic [OUT_W-1:0] zext;

  // Build both base extensions, then select the requested form.
  // Bits are filled first and then overwritten, so IN_W == OUT_W needs no zero-width replication.
  always_comb begin
    sext           = {OUT_W{in_imm[IN_W-1]}};
    sext[IN_W-1:0] = in_imm;
    zext           = '0;
    zext[IN_W-1:0] = in_imm;
    ext_data       = sext;
    case (imm_mode_e'(in_mode))
      IMM_SEXT:      ext_data = sext;
      IMM_ZEXT:      ext_data = zext;
      IMM_SEXT_SHL1: ext_data = {sext[OUT_W-2:0], 1'b0};
      IMM_UPPER:     ext_data = zext << (OUT_W - IN_W);
      default:       ext_data = sext;
    endcase
  end

endmodule : imm_ext_core

// File: rtl/imm_ext_pipe.sv
// Pipelined immediate extender: extension followed by a 2-entry skid FIFO
// with valid/ready on both sides and a synchronous flush.
// Optional build macro IMM_EXT_PERF_EN adds a saturating stall_cnt output.
import imm_ext_pkg::*;

module imm_ext_pipe #(
  parameter int unsigned IN_W  = 9,
  parameter int unsigned OUT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IN_W-1:0]  in_imm,
  input  logic [1:0]       in_mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] out_data
`ifdef IMM_EXT_PERF_EN
  ,
  output logic [15:0]      stall_cnt
`endif
);

  if (IN_W < 2 || IN_W > OUT_W) begin : g_bad_width
    $error("imm_ext_pipe: IN_W must lie in 2..OUT_W");
  end

  logic [OUT_W-1:0] ext_data;
  logic [OUT_W-1:0] data0_q, data0_d;
  logic [OUT_W-1:0] data1_q, data1_d;
  logic [1:0]       count_q, count_d;
  logic             push, pop;

  imm_ext_core #(
    .IN_W  (IN_W),
    .OUT_W (OUT_W)
  ) u_core (
    .in_imm   (in_imm),
    .in_mode  (in_mode),
    .ext_data (ext_data)
  );

  // Handshake flags depend on registered occupancy only, never on out_ready.
  always_comb begin
    in_ready  = (count_q < 2'(FIFO_DEPTH));
    out_valid = (count_q != '0);
    out_data  = data0_q;
    push      = in_valid & in_ready;
    pop       = out_valid & out_ready;
  end

  // Next-state for occupancy and entries; flush wins over push and pop.
  always_comb begin
    count_d = count_q;
    data0_d = data0_q;
    data1_d = data1_q;
    if (flush) begin
      count_d = '0;
    end else begin
      case ({push, pop})
        2'b10: begin
          if (count_q == '0) data0_d = ext_data;
          else               data1_d = ext_data;
          count_d = count_q + 2'd1;
        end
        2'b01: begin
          data0_d = data1_q;
          count_d = count_q - 2'd1;
        end
        // Only reachable at count 1: the head leaves and the newcomer takes its slot.
        2'b11:   data0_d = ext_data;
        default: ;
      endcase
    end
  end

  // FIFO state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
      data0_q <= '0;
      data1_q <= '0;
    end else begin
      count_q <= count_d;
      data0_q <= data0_d;
      data1_q <= data1_d;
    end
  end

`ifdef IMM_EXT_PERF_EN
  logic [15:0] stall_cnt_q, stall_cnt_d;

  // Saturating count of cycles where the producer is held off.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (in_valid && !in_ready && stall_cnt_q != '1) stall_cnt_d = stall_cnt_q + 16'd1;
  end

  // Stall counter register; only reset clears it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) stall_cnt_q <= '0;
    else        stall_cnt_q <= stall_cnt_d;
  end

  assign stall_cnt = stall_cnt_q;
`endif

endmodule : imm_ext_pipe

// File: tb/tb_imm_ext_pipe.sv
// Scoreboard bench for imm_ext_pipe with directed, hand-computed vectors.
import imm_ext_pkg::*;

module tb_imm_ext_pipe;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [8:0]  in_imm = '0;
  logic [1:0]  in_mode = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [15:0] out_data;
`ifdef IMM_EXT_PERF_EN
  logic [15:0] stall_cnt;
`endif

  logic [15:0] exp_cur = '0;
  logic [15:0] sb[$];
  int          n_checks = 0;
  int          n_fail   = 0;

  imm_ext_pipe #(
    .IN_W  (9),
    .OUT_W (16)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_imm    (in_imm),
    .in_mode   (in_mode),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data)
`ifdef IMM_EXT_PERF_EN
    ,
    .stall_cnt (stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endfunction

  // Input side: record the expected result of every accepted immediate.
  always @(negedge clk) begin
    if (rst_n) begin
      if (flush) sb.delete();
      else if (in_valid && in_ready) sb.push_back(exp_cur);
    end
  end

  // Output side: every pop must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (rst_n && !flush && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL sb_underflow: got %h expected none", out_data);
      end else begin
        check("sb_data", {16'h0, out_data}, {16'h0, sb.pop_front()});
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [8:0] imm, input imm_mode_e mode, input logic [15:0] exp);
    in_valid = 1'b1;
    in_imm   = imm;
    in_mode  = mode;
    exp_cur  = exp;
  endtask

  logic [8:0]  mv_imm [6] = '{9'h1F0, 9'h1F0, 9'h1F0, 9'h1F0, 9'h0A5, 9'h0FF};
  imm_ext_pkg::imm_mode_e mv_mode [6] = '{IMM_SEXT, IMM_ZEXT, IMM_SEXT_SHL1, IMM_UPPER, IMM_UPPER, IMM_SEXT_SHL1};
  logic [15:0] mv_exp [6] = '{16'hFFF0, 16'h01F0, 16'hFFE0, 16'hF800, 16'h5280, 16'h01FE};

  initial begin
    logic acc;
    // Reset
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    step();
    check("rst_out_valid", {31'h0, out_valid}, 32'h0);
    check("rst_out_data", {16'h0, out_data}, 32'h0);
    check("rst_in_ready", {31'h0, in_ready}, 32'h1);

    // Mode vectors, back to back with out_ready high
    out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      drive(mv_imm[i], mv_mode[i], mv_exp[i]);
      step();
      check("mode_valid", {31'h0, out_valid}, 32'h1);
      check("mode_data", {16'h0, out_data}, {16'h0, mv_exp[i]});
    end
    in_valid = 1'b0;
    step();
    check("mode_drained", {31'h0, out_valid}, 32'h0);

    // Backpressure
    out_ready = 1'b0;
    drive(9'h001, IMM_SEXT, 16'h0001);
    step();
    check("bp_ready_a", {31'h0, in_ready}, 32'h1);
    drive(9'h002, IMM_SEXT, 16'h0002);
    step();
    check("bp_ready_b", {31'h0, in_ready}, 32'h0);
    drive(9'h003, IMM_SEXT, 16'h0003);
    step();
    check("bp_hold_c", {31'h0, in_ready}, 32'h0);
    check("bp_head", {16'h0, out_data}, 32'h0001);
    out_ready = 1'b1;
    acc = 1'b0;
    for (int i = 0; i < 8 && !acc; i++) begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    check("bp_c_accept", {31'h0, acc}, 32'h1);
    repeat (3) step();
    check("bp_sb_empty", sb.size(), 32'h0);
    check("bp_drained", {31'h0, out_valid}, 32'h0);

    // Push and pop together at occupancy 1
    for (int k = 0; k < 6; k++) begin
      drive(9'(9'h011 + k), IMM_SEXT, 16'(16'h0011 + k));
      step();
      check("pp_valid", {31'h0, out_valid}, 32'h1);
      check("pp_data", {16'h0, out_data}, 32'(16'h0011 + k));
      check("pp_ready", {31'h0, in_ready}, 32'h1);
    end
    in_valid = 1'b0;
    step();
    check("pp_drained", {31'h0, out_valid}, 32'h0);

    // Flush at occupancy 2 with a pending push
    out_ready = 1'b0;
    drive(9'h0AA, IMM_SEXT, 16'h00AA);
    step();
    drive(9'h1AB, IMM_SEXT, 16'hFFAB);
    step();
    drive(9'h0CC, IMM_ZEXT, 16'h00CC);
    flush = 1'b1;
    step();
    flush = 1'b0;
    in_valid = 1'b0;
    check("fl2_valid", {31'h0, out_valid}, 32'h0);
    check("fl2_ready", {31'h0, in_ready}, 32'h1);
    check("fl2_data", {16'h0, out_data}, 32'h00AA);
    // Flush at occupancy 1 while a push is accepted
    drive(9'h0DD, IMM_ZEXT, 16'h00DD);
    step();
    drive(9'h0EE, IMM_ZEXT, 16'h00EE);
    flush = 1'b1;
    step();
    flush = 1'b0;
    in_valid = 1'b0;
    check("fl1_valid", {31'h0, out_valid}, 32'h0);
    check("fl1_data", {16'h0, out_data}, 32'h00DD);
    out_ready = 1'b1;
    drive(9'h005, IMM_SEXT, 16'h0005);
    step();
    in_valid = 1'b0;
    check("fl_after_data", {16'h0, out_data}, 32'h0005);
    step();
    check("fl_after_empty", {31'h0, out_valid}, 32'h0);
    check("fl_sb_empty", sb.size(), 32'h0);

    // Asynchronous reset between edges with two entries held
    out_ready = 1'b0;
    drive(9'h033, IMM_SEXT, 16'h0033);
    step();
    drive(9'h034, IMM_SEXT, 16'h0034);
    step();
    in_valid = 1'b0;
    #3;
    rst_n = 1'b0;
    #1;
    check("arst_valid", {31'h0, out_valid}, 32'h0);
    check("arst_data", {16'h0, out_data}, 32'h0);
    check("arst_ready", {31'h0, in_ready}, 32'h1);
`ifdef IMM_EXT_PERF_EN
    check("arst_stall", {16'h0, stall_cnt}, 32'h0);
`endif
    sb.delete();
    @(negedge clk);
    #1;
    rst_n = 1'b1;
    step();
    drive(9'h021, IMM_SEXT, 16'h0021);
    step();
    drive(9'h022, IMM_SEXT, 16'h0022);
    step();
    check("arst_full", {31'h0, in_ready}, 32'h0);
`ifdef IMM_EXT_PERF_EN
    check("stall_0", {16'h0, stall_cnt}, 32'h0);
`endif
    step();
`ifdef IMM_EXT_PERF_EN
    check("stall_1", {16'h0, stall_cnt}, 32'h1);
`endif
    step();
`ifdef IMM_EXT_PERF_EN
    check("stall_2", {16'h0, stall_cnt}, 32'h2);
`endif
    in_valid = 1'b0;
    out_ready = 1'b1;
    repeat (4) step();
    check("arst_sb_empty", sb.size(), 32'h0);
    check("arst_drained", {31'h0, out_valid}, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule : tb_imm_ext_pipe

// File: doc/imm_ext_pipe.md
Name: imm_ext_pipe

Overview:
Parametrised, pipelined immediate extender for the WISC-S25 datapath. Takes an IN_W-bit instruction immediate and produces an OUT_W-bit operand in one of four modes: sign-extend, zero-extend, sign-extend then shift left 1 (branch offset), or upper placement (LHB-style). The result is held in a 2-entry skid buffer with valid/ready handshakes on both sides, so decode can stall or flush without losing operands.

Parameters:
IN_W, 9, immediate field width; legal range 2..OUT_W
OUT_W, 16, extended operand width
(Illegal widths are caught by an elaboration-time check.)

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
flush  input  1  synchronous clear of all buffered entries
in_valid  input  1  producer has an immediate
in_ready  output  1  buffer can accept this cycle
in_imm  input  IN_W  raw immediate field
in_mode  input  2  00 SEXT, 01 ZEXT, 10 SEXT_SHL1, 11 UPPER
out_valid  output  1  out_data holds a valid operand
out_ready  input  1  consumer accepts this cycle
out_data  output  OUT_W  extended operand

Behaviour:
- Reset: async on rst_n low. Entry count = 0, out_valid = 0, out_data = 0, in_ready = 1 on the first cycle after release.
- Extension, combinational, applied before buffering:
  - SEXT: {(OUT_W-IN_W){imm[IN_W-1]}, imm}
  - ZEXT: zero-fill the upper bits
  - SEXT_SHL1: SEXT result shifted left 1, truncated to OUT_W, LSB = 0
  - UPPER: imm << (OUT_W-IN_W); low bits are zero
- Storage: 2-entry FIFO, head = entry 0.
  - out_data = head data; out_valid = (count != 0).
  - out_data is held at its last value when empty; it is not cleared.
  - in_ready = (count < 2). This is registered state only, with no combinational path from out_ready.
- Push = in_valid & in_ready. Pop = out_valid & out_ready.
- Latency: an accepted immediate appears on out_data/out_valid the next cycle. There is no bypass when empty.
- Count transitions:
  - push only: count+1
  - pop only: count-1; entry 1 shifts to entry 0
  - push & pop at count 1: count stays 1; the new data loads entry 0
  - push & pop at count 2: not possible, since in_ready = 0
- Order is strictly FIFO.
- flush:
  - Count goes to 0 next cycle.
  - Overrides push and pop in the same cycle; the pushed item is discarded.
  - out_data is unchanged.
- Inputs are ignored while in_valid = 0.
- in_mode and in_imm are sampled only on push.
- Reset asserted mid-stream discards all entries immediately, independent of clk.

Optional Feature:
IMM_EXT_PERF_EN
- Defined:
  - Adds output stall_cnt [15:0].
  - Counts cycles with in_valid & ~in_ready, saturating at 16'hFFFF.
  - Clears on reset only; flush does not clear it.
- Undefined: port and counter are absent; behaviour is otherwise identical.

Decomposition:
- Package imm_ext_pkg holds:
  - mode encodings IMM_SEXT=2'b00, IMM_ZEXT=2'b01, IMM_SEXT_SHL1=2'b10, IMM_UPPER=2'b11
  - FIFO depth constant 2
- Sub-module imm_ext_core: purely combinational (in_imm, in_mode) -> OUT_W result, same parameters.
- imm_ext_pipe instantiates imm_ext_core and owns the buffer and handshake logic.

Test Plan:
- IN_W=9, OUT_W=16, out_ready=1, four sequential pushes of 9'h1F0 in SEXT, ZEXT, SEXT_SHL1 and UPPER -> out_data 16'hFFF0, 16'h01F0, 16'hFFE0, 16'hF800 respectively, each one cycle after its push.
- UPPER 9'h0A5 -> 16'h5280; SEXT_SHL1 9'h0FF -> 16'h01FE.
- Backpressure: out_ready=0, push A=9'h001, B=9'h002, C=9'h003 (SEXT) on consecutive cycles ->
  - in_ready drops after B; C is held off
  - raise out_ready -> outputs 16'h0001, 16'h0002, 16'h0003 in order, with no loss or duplication
- Simultaneous push/pop at count 1 for 5 consecutive cycles -> count stays 1, in_ready stays 1, each value emerges exactly one cycle after its push.
- flush with count=2 and in_valid=1 -> next cycle out_valid=0, in_ready=1, the flushed push never appears, out_data unchanged.
- rst_n pulsed low asynchronously between edges with count=2 -> out_valid=0 and out_data=0 immediately; with IMM_EXT_PERF_EN, stall_cnt=0 and then increments once per blocked cycle.
